vsync_line_counter: RTL and testbench

- Vertical timing stage directly downstream of the horizontal sync generator.
- Counts lines by detecting the rising edge of the horizontal stage's LineEnd level.
- Produces vsync, yposition, an active-line flag, a one-clock FrameEnd pulse and a free-running frame counter.
- Outputs feed the VGA connector and the pong game logic.

---
 rtl/vsync_line_counter.sv | 98 +++++++++
 tb/tb_vsync_line_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vsync_line_counter.sv
// -----------------------------------------------------------------------------
// vsync_line_counter
//
// Vertical timing stage that sits right after the horizontal sync generator.
// Each rising edge of the horizontal stage's LineEnd level advances the line
// counter by one. From that counter it derives the active-low vertical sync,
// the active-line flag, a one-clock FrameEnd pulse on wrap, and a free-running
// frame counter.
//
// Parameters
//   yresolution : width of the line timing inputs and of yposition
//   framebits   : width of FrameCount
//
// Ports
//   clock       in   system clock (shared with the horizontal stage)
//   reset       in   asynchronous active-low reset
//   LineEnd     in   end-of-line level; may stay high for several clocks
//   ActiveVideo in   visible lines per frame
//   FrontPorch  in   lines between active video and sync
//   SynchPulse  in   sync width in lines
//   BackPorch   in   lines after sync
//   vsync       out  active-low vertical sync
//   yposition   out  current line number
//   ActiveLine  out  high while yposition < ActiveVideo
//   FrameEnd    out  one-clock pulse on the edge where the counter wraps to 0
//   FrameCount  out  completed frames, wraps modulo 2^framebits
// -----------------------------------------------------------------------------
module vsync_line_counter #(
  parameter int yresolution = 10,
  parameter int framebits   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   LineEnd,
  input  logic [yresolution-1:0] ActiveVideo,
  input  logic [yresolution-1:0] FrontPorch,
  input  logic [yresolution-1:0] SynchPulse,
  input  logic [yresolution-1:0] BackPorch,
  output logic                   vsync,
  output logic [yresolution-1:0] yposition,
  output logic                   ActiveLine,
  output logic                   FrameEnd,
  output logic [framebits-1:0]   FrameCount
);

  logic [yresolution-1:0] ycount;
  logic                   LineEnd_q;
  logic                   line_tick;
  logic [yresolution-1:0] end_count;
  logic [yresolution:0]   sync_start;
  logic [yresolution:0]   sync_stop;
  logic [yresolution:0]   ycount_inc;
  logic                   wrap;

  // Frame length wraps modulo 2^yresolution; sync window uses one extra bit.
  assign end_count  = ActiveVideo + FrontPorch + SynchPulse + BackPorch;
  assign sync_start = {1'b0, ActiveVideo} + {1'b0, FrontPorch};
  assign sync_stop  = sync_start + {1'b0, SynchPulse};

  // ycount+1 >= EndCount is the same test as ycount >= EndCount-1 for a
  // non-zero frame length, and it is always true for EndCount == 0, so the
  // degenerate zero-length frame wraps on every tick without a special case.
  // The >= form also recovers when the frame is shortened mid-frame.
  assign ycount_inc = {1'b0, ycount} + (yresolution+1)'(1);
  assign wrap       = (ycount_inc >= {1'b0, end_count});

  // LineEnd_q resets high so a LineEnd already high at reset release is
  // not taken as a new line.
  assign line_tick = LineEnd & ~LineEnd_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      LineEnd_q  <= 1'b1;
      ycount     <= '0;
      FrameEnd   <= 1'b0;
      FrameCount <= '0;
    end else begin
      LineEnd_q <= LineEnd;
      FrameEnd  <= 1'b0;
      if (line_tick) begin
        if (wrap) begin
          ycount     <= '0;
          FrameEnd   <= 1'b1;
          FrameCount <= FrameCount + 1'b1;
        end else begin
          ycount <= ycount + 1'b1;
        end
      end
    end
  end

  // Decoded straight from the counter register: no latency versus yposition.
  assign yposition  = ycount;
  assign vsync      = ~(({1'b0, ycount} >= sync_start) &&
                        ({1'b0, ycount} <  sync_stop));
  assign ActiveLine = (ycount < ActiveVideo);

endmodule

// File: tb/tb_vsync_line_counter.sv
// -----------------------------------------------------------------------------
// tb_vsync_line_counter
//
// Randomised bench for vsync_line_counter. A driver process applies LineEnd,
// reset and the timing inputs on the falling clock edge, advances a reference
// model of the frame rules and queues the outputs expected after the next
// rising edge. A separate monitor pops and compares those one time unit after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_vsync_line_counter;

  localparam int YR = 10;
  localparam int FB = 8;

  logic          clock = 1'b1;
  logic          reset;
  logic          LineEnd;
  logic [YR-1:0] ActiveVideo, FrontPorch, SynchPulse, BackPorch;
  logic          vsync;
  logic [YR-1:0] yposition;
  logic          ActiveLine;
  logic          FrameEnd;
  logic [FB-1:0] FrameCount;

  vsync_line_counter #(.yresolution(YR), .framebits(FB)) dut (
    .clock      (clock),
    .reset      (reset),
    .LineEnd    (LineEnd),
    .ActiveVideo(ActiveVideo),
    .FrontPorch (FrontPorch),
    .SynchPulse (SynchPulse),
    .BackPorch  (BackPorch),
    .vsync      (vsync),
    .yposition  (yposition),
    .ActiveLine (ActiveLine),
    .FrameEnd   (FrameEnd),
    .FrameCount (FrameCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    int y;
    int fe;
    int fc;
    int vs;
    int al;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int dut_fe_cnt = 0;

  // Timing settings currently applied by the driver.
  int av, fp, sp, bp;

  // Reference model: line number, frame count, last LineEnd level seen.
  int m_y, m_fc, m_fe, m_frames;
  bit m_last_le;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, predict the state after the next
  // rising edge, queue the prediction.
  task automatic step(input bit le, input bit rst);
    int frame_len;
    exp_t e;
    @(negedge clock);
    LineEnd     = le;
    reset       = rst;
    ActiveVideo = YR'(av);
    FrontPorch  = YR'(fp);
    SynchPulse  = YR'(sp);
    BackPorch   = YR'(bp);
    if (!rst) begin
      m_y = 0; m_fc = 0; m_fe = 0; m_last_le = 1'b1;
    end else begin
      m_fe = 0;
      if (le && !m_last_le) begin
        frame_len = (av + fp + sp + bp) % (1 << YR);
        if (frame_len == 0 || m_y >= frame_len - 1) begin
          m_y = 0;
          m_fe = 1;
          m_fc = (m_fc + 1) % (1 << FB);
          m_frames++;
        end else begin
          m_y++;
        end
      end
      m_last_le = le;
    end
    e.y  = m_y;
    e.fe = m_fe;
    e.fc = m_fc;
    e.vs = (m_y >= av + fp && m_y < av + fp + sp) ? 0 : 1;
    e.al = (m_y < av) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic line(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b1);
    repeat (lo) step(1'b0, 1'b1);
  endtask

  task automatic rand_line();
    line($urandom_range(1, 5), $urandom_range(1, 4));
  endtask

  task automatic drain();
    @(posedge clock);
    #2;
  endtask

  task automatic set_vga();
    av = 480; fp = 10; sp = 2; bp = 33;
  endtask

  // Monitor: compare one queued prediction after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("yposition",  int'(yposition),  e.y);
        chk("FrameEnd",   int'(FrameEnd),   e.fe);
        chk("FrameCount", int'(FrameCount), e.fc);
        chk("vsync",      int'(vsync),      e.vs);
        chk("ActiveLine", int'(ActiveLine), e.al);
        if (FrameEnd) dut_fe_cnt++;
      end
    end
  end

  initial begin
    int base;
    int guard;
    int target;
    m_y = 0; m_fc = 0; m_fe = 0; m_frames = 0; m_last_le = 1'b1;
    set_vga();
    reset = 1'b0;
    LineEnd = 1'b1;
    ActiveVideo = YR'(av); FrontPorch = YR'(fp);
    SynchPulse = YR'(sp);  BackPorch = YR'(bp);

    // Reset held with LineEnd high, release while still high, then drop it.
    repeat (3) step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    drain();
    chk("reset_release_y",  int'(yposition), 0);
    chk("reset_release_vs", int'(vsync), 1);
    chk("reset_release_al", int'(ActiveLine), 1);

    // Two full 640x480 frames, 5-clock-wide LineEnd pulses.
    guard = 0;
    while (m_frames < 2 && guard < 2000) begin
      line(5, $urandom_range(1, 4));
      guard++;
    end
    drain();
    chk("fc_after_two_frames", int'(FrameCount), 2);
    chk("y_after_two_frames",  int'(yposition), 0);

    // Shorten the frame while at line 500: next tick must wrap.
    guard = 0;
    while (m_y != 500 && guard < 2000) begin
      rand_line();
      guard++;
    end
    bp = 5;
    target = m_frames + 2;
    rand_line();
    drain();
    chk("shortened_wrap_y",  int'(yposition), 0);
    chk("shortened_wrap_fc", int'(FrameCount), 3);
    guard = 0;
    while (m_frames < target && guard < 2000) begin
      rand_line();
      guard++;
    end

    // Reset at line 300 coinciding with a LineEnd rising edge.
    guard = 0;
    while (m_y != 300 && guard < 2000) begin
      rand_line();
      guard++;
    end
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    #1;
    chk("async_reset_y",  int'(yposition), 0);
    chk("async_reset_fc", int'(FrameCount), 0);
    chk("async_reset_fe", int'(FrameEnd), 0);
    repeat (2) step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    target = m_frames + 1;
    guard = 0;
    while (m_frames < target && guard < 2000) begin
      rand_line();
      guard++;
    end
    drain();
    chk("fc_after_reset_frame", int'(FrameCount), 1);

    // 256 short frames: FrameCount wraps back to 0.
    av = 4; fp = 1; sp = 1; bp = 2;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    drain();
    base = dut_fe_cnt;
    repeat (256 * 8) line($urandom_range(1, 3), $urandom_range(1, 2));
    drain();
    chk("frameend_pulses_256", dut_fe_cnt - base, 256);
    chk("framecount_wrapped",  int'(FrameCount), 0);

    // All timing inputs zero: every tick is a frame end.
    av = 0; fp = 0; sp = 0; bp = 0;
    base = dut_fe_cnt;
    repeat (20) rand_line();
    drain();
    chk("zero_timing_pulses", dut_fe_cnt - base, 20);
    chk("zero_timing_fc",     int'(FrameCount), 20);
    chk("zero_timing_vs",     int'(vsync), 1);
    chk("zero_timing_al",     int'(ActiveLine), 0);

    drain();
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
